// File: rtl/credit_pkg.sv
// -----------------------------------------------------------------------------
// credit_pkg
// Shared definitions for the credit-based requester and its responder.
//   ID_W / PAYLOAD_W : request field widths
//   RB_DEPTH         : retry buffer depth
//   req_t            : packed {id, payload} request word
//   rb_entry_t       : one retry-buffer slot (valid, granted, grant rank, request)
// -----------------------------------------------------------------------------
package credit_pkg;

    localparam int ID_W      = 3;
    localparam int PAYLOAD_W = 5;
    localparam int RB_DEPTH  = 4;

    // Counter wide enough to hold 0..RB_DEPTH inclusive.
    localparam int RB_CNT_W  = $clog2(RB_DEPTH + 1);
    // Grant rank orders granted entries by the time they were granted.
    localparam int RANK_W    = $clog2(RB_DEPTH);

    localparam logic [RB_CNT_W-1:0] RSV_MAX  = RB_CNT_W'(RB_DEPTH);
    localparam logic [RB_CNT_W-1:0] CNT_ONE  = RB_CNT_W'(1);
    localparam logic [RANK_W-1:0]   RANK_ONE = RANK_W'(1);

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [PAYLOAD_W-1:0] payload;
    } req_t;

    typedef struct packed {
        logic              vld;
        logic              gnt;
        logic [RANK_W-1:0] rank;
        req_t              req;
    } rb_entry_t;

endpackage

// File: rtl/credit_requester_if.sv
// -----------------------------------------------------------------------------
// credit_requester_if
// Groups the upstream request handshake, the request channel to the responder
// and the credit-return channel.
//   master : the requester side (credit_requester)
//   slave  : upstream source + responder side (testbench / system)
// -----------------------------------------------------------------------------
interface credit_requester_if;
    import credit_pkg::*;

    // Upstream new-request handshake
    logic                 req_valid_i;
    logic [ID_W-1:0]      req_id_i;
    logic [PAYLOAD_W-1:0] req_payload_i;
    logic                 req_ready_o;

    // Request channel to responder
    logic                 tx_valid_o;
    logic [ID_W-1:0]      tx_id_o;
    logic [PAYLOAD_W-1:0] tx_payload_o;
    logic                 tx_credit_o;
    logic                 tx_ready_i;
    logic                 tx_retry_i;

    // Credit return from responder
    logic                 credit_gnt_i;
    logic [ID_W-1:0]      credit_id_i;

    modport master (
        input  req_valid_i, req_id_i, req_payload_i,
        output req_ready_o,
        output tx_valid_o, tx_id_o, tx_payload_o, tx_credit_o,
        input  tx_ready_i, tx_retry_i,
        input  credit_gnt_i, credit_id_i
    );

    modport slave (
        output req_valid_i, req_id_i, req_payload_i,
        input  req_ready_o,
        input  tx_valid_o, tx_id_o, tx_payload_o, tx_credit_o,
        output tx_ready_i, tx_retry_i,
        output credit_gnt_i, credit_id_i
    );

endinterface

// File: rtl/credit_retry_buf.sv
// -----------------------------------------------------------------------------
// credit_retry_buf
// Retry buffer holding requests that were bounced by the responder and are
// waiting for a credit. Slots are kept compacted, index 0 oldest.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   push_i / push_req_i   : capture a retried request as ungranted
//   gnt_i / gnt_id_i      : credit grant; marks oldest ungranted slot with that id
//   gnt_miss_o            : grant matched no slot present before the edge
//   pop_i / pop_req_o     : remove the earliest-granted slot (data valid when
//                           gnt_pending_o is high)
//   count_o               : number of occupied slots
//   gnt_pending_o         : at least one granted slot is waiting
// -----------------------------------------------------------------------------
module credit_retry_buf
    import credit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  req_t                push_req_i,
    input  logic                gnt_i,
    input  logic [ID_W-1:0]     gnt_id_i,
    output logic                gnt_miss_o,
    input  logic                pop_i,
    output req_t                pop_req_o,
    output logic [RB_CNT_W-1:0] count_o,
    output logic                gnt_pending_o
);

    rb_entry_t ent_q  [RB_DEPTH];
    rb_entry_t ent_d  [RB_DEPTH];
    rb_entry_t marked [RB_DEPTH];

    int   gnt_idx;
    int   pop_idx;
    int   n_occ;
    int   n_gnt;
    int   push_pos;
    logic gnt_hit;
    logic pop_hit;
    logic do_pop;
    logic [RANK_W-1:0] new_rank;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise synthesis infers a latch to hold its previous value.
        gnt_hit   = 1'b0;
        gnt_idx   = 0;
        pop_hit   = 1'b0;
        pop_idx   = 0;
        pop_req_o = '0;
        n_occ     = 0;
        n_gnt     = 0;

        for (int i = 0; i < RB_DEPTH; i++) begin
            if (ent_q[i].vld) begin
                n_occ = n_occ + 1;
            end
            if (ent_q[i].vld && ent_q[i].gnt) begin
                n_gnt = n_gnt + 1;
            end
            // Oldest ungranted slot with matching id takes the credit.
            if (!gnt_hit && ent_q[i].vld && !ent_q[i].gnt && ent_q[i].req.id == gnt_id_i) begin
                gnt_hit = 1'b1;
                gnt_idx = i;
            end
            // Rank 0 is the earliest grant still waiting, so reissue follows
            // grant order even when grants arrive out of buffer order.
            if (ent_q[i].vld && ent_q[i].gnt && ent_q[i].rank == '0) begin
                pop_hit   = 1'b1;
                pop_idx   = i;
                pop_req_o = ent_q[i].req;
            end
        end

        gnt_hit       = gnt_hit & gnt_i;
        gnt_miss_o    = gnt_i & ~gnt_hit;
        gnt_pending_o = (n_gnt != 0);
        count_o       = RB_CNT_W'(n_occ);
        do_pop        = pop_i & pop_hit;
        new_rank      = RANK_W'(n_gnt - (do_pop ? 1 : 0));

        // Stage 1: rank update and grant marking on the pre-edge positions.
        for (int i = 0; i < RB_DEPTH; i++) begin
            marked[i] = ent_q[i];
            if (do_pop && ent_q[i].vld && ent_q[i].gnt && i != pop_idx) begin
                marked[i].rank = ent_q[i].rank - RANK_ONE;
            end
            if (gnt_hit && i == gnt_idx) begin
                marked[i].gnt  = 1'b1;
                marked[i].rank = new_rank;
            end
        end

        // Stage 2: close the gap left by the popped slot.
        for (int i = 0; i < RB_DEPTH; i++) begin
            ent_d[i] = marked[i];
        end
        if (do_pop) begin
            for (int i = 0; i < RB_DEPTH - 1; i++) begin
                if (i >= pop_idx) begin
                    ent_d[i] = marked[i + 1];
                end
            end
            ent_d[RB_DEPTH-1] = '0;
        end

        // Stage 3: append the retried request behind the survivors.
        push_pos = n_occ - (do_pop ? 1 : 0);
        for (int i = 0; i < RB_DEPTH; i++) begin
            if (push_i && i == push_pos) begin
                ent_d[i].vld  = 1'b1;
                ent_d[i].gnt  = 1'b0;
                ent_d[i].rank = '0;
                ent_d[i].req  = push_req_i;
            end
        end
    end

    // NOTE: this storage carries valid/granted flags, so unlike a plain data
    // RAM it must be reset; only the control bits strictly need it, but the
    // array is tiny and clearing whole entries keeps the outputs clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RB_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RB_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: rtl/credit_requester.sv
// -----------------------------------------------------------------------------
// credit_requester
// Issues requests to a responder that may bounce them with a retry. Bounced
// requests wait in a retry buffer until the responder returns a credit for
// their id, then are reissued as credited requests that cannot be bounced.
// Ports:
//   clk          : clock, all state on the rising edge
//   reset        : synchronous active-high reset
//   bus (master) : upstream req_*, request channel tx_*, credit return credit_*
//   err_o        : sticky protocol error (unmatched grant, retry of credited)
//   retry_cnt_o  : saturating retry counter, present only when the macro
//                  CREDIT_REQ_STATS_EN is defined
// -----------------------------------------------------------------------------
module credit_requester
    import credit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    credit_requester_if.master bus,
    output logic               err_o
`ifdef CREDIT_REQ_STATS_EN
    ,
    output logic [7:0]         retry_cnt_o
`endif
);

    // One-entry output register
    logic tx_valid_q, tx_valid_d;
    logic tx_credit_q, tx_credit_d;
    req_t tx_req_q, tx_req_d;

    // Buffer entries plus an uncredited request held in the output register
    logic [RB_CNT_W-1:0] rsv_cnt_q, rsv_cnt_d;
    logic err_q, err_d;

    logic accept;
    logic retry_seen;
    logic retry;
    logic bad_retry;
    logic loadable;
    logic pop;
    logic req_ready;
    logic up_load;

    req_t                pop_req;
    logic                gnt_miss;
    logic                gnt_pending;
    logic [RB_CNT_W-1:0] rb_count;

    credit_retry_buf u_retry_buf (
        .clk           (clk),
        .reset         (reset),
        .push_i        (retry),
        .push_req_i    (tx_req_q),
        .gnt_i         (bus.credit_gnt_i),
        .gnt_id_i      (bus.credit_id_i),
        .gnt_miss_o    (gnt_miss),
        .pop_i         (pop),
        .pop_req_o     (pop_req),
        .count_o       (rb_count),
        .gnt_pending_o (gnt_pending)
    );

    always_comb begin
        accept     = tx_valid_q & bus.tx_ready_i;
        retry_seen = tx_valid_q & bus.tx_retry_i & ~bus.tx_ready_i;
        // A credited request may not be bounced: hold it and flag the error.
        retry      = retry_seen & ~tx_credit_q;
        bad_retry  = retry_seen &  tx_credit_q;
        loadable   = ~tx_valid_q | accept | retry;
        pop        = loadable & gnt_pending;
        // Holding back new work at rsv_cnt == RB_DEPTH guarantees every
        // uncredited request in flight has a buffer slot waiting for it.
        req_ready  = loadable & ~gnt_pending & (rsv_cnt_q < RSV_MAX);
        up_load    = req_ready & bus.req_valid_i;

        tx_valid_d  = tx_valid_q;
        tx_credit_d = tx_credit_q;
        tx_req_d    = tx_req_q;
        if (pop) begin
            tx_valid_d  = 1'b1;
            tx_credit_d = 1'b1;
            tx_req_d    = pop_req;
        end else if (up_load) begin
            tx_valid_d  = 1'b1;
            tx_credit_d = 1'b0;
            tx_req_d    = '{id: bus.req_id_i, payload: bus.req_payload_i};
        end else if (accept || retry) begin
            tx_valid_d  = 1'b0;
            tx_credit_d = 1'b0;
        end

        // A retry only moves a reservation from the register to the buffer,
        // so it leaves the count unchanged.
        rsv_cnt_d = rsv_cnt_q;
        if (up_load) begin
            rsv_cnt_d = rsv_cnt_d + CNT_ONE;
        end
        if (accept && !tx_credit_q) begin
            rsv_cnt_d = rsv_cnt_d - CNT_ONE;
        end
        if (pop) begin
            rsv_cnt_d = rsv_cnt_d - CNT_ONE;
        end

        err_d = err_q | bad_retry | gnt_miss;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q  <= 1'b0;
            tx_credit_q <= 1'b0;
            tx_req_q    <= '0;
            rsv_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            tx_valid_q  <= tx_valid_d;
            tx_credit_q <= tx_credit_d;
            tx_req_q    <= tx_req_d;
            rsv_cnt_q   <= rsv_cnt_d;
            err_q       <= err_d;
        end
    end

`ifdef CREDIT_REQ_STATS_EN
    logic [7:0] retry_cnt_q, retry_cnt_d;

    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (retry && retry_cnt_q != 8'hFF) begin
            retry_cnt_d = retry_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retry_cnt_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign retry_cnt_o = retry_cnt_q;
`endif

    assign bus.req_ready_o  = req_ready;
    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.tx_credit_o  = tx_credit_q;
    assign bus.tx_id_o      = tx_req_q.id;
    assign bus.tx_payload_o = tx_req_q.payload;
    assign err_o            = err_q;

    // The reservation counter must always equal what it stands for.
    rsv_matches_buffer : assert property (@(posedge clk) disable iff (reset)
        (rb_count + RB_CNT_W'(tx_valid_q & ~tx_credit_q)) == rsv_cnt_q);

endmodule

// File: doc/credit_requester.md
CREDIT_REQUESTER -- requirements
Module: credit_requester

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_valid_i in 1, req_id_i in 3, req_payload_i in 5, req_ready_o out 1; upstream new-request valid/ready handshake.
REQ-004 SHALL have ports: tx_valid_o out 1, tx_id_o out 3, tx_payload_o out 5, tx_credit_o out 1 (1 = credited reissue), tx_ready_i in 1, tx_retry_i in 1; request channel to responder.
REQ-005 SHALL have ports: credit_gnt_i in 1, credit_id_i in 3; credit return from responder.
REQ-006 SHALL have port: err_o out 1; sticky protocol-error flag.

Function
REQ-007 SHALL hold the current request in a one-entry output register; tx_* outputs are driven directly from it.
REQ-008 SHALL treat tx_valid_o & tx_ready_i as accept (request complete), and tx_valid_o & tx_retry_i & ~tx_ready_i & ~tx_credit_o as retry.
REQ-009 SHALL hold tx_* stable while tx_valid_o=1 and neither accept nor retry occurs.
REQ-010 SHALL, on retry, copy {id,payload} into a 4-entry FIFO-ordered retry buffer as ungranted and free the output register in the same edge.
REQ-011 SHALL, on credit_gnt_i, mark the oldest ungranted buffer entry with id == credit_id_i as granted; a grant matching no entry present before the edge sets err_o.
REQ-012 SHALL load the output register when empty or completing (accept or retry) this cycle; load source priority: oldest granted buffer entry (tx_credit_o=1, entry removed on load), else upstream request (tx_credit_o=0).
REQ-013 SHALL give latency 1: req_valid_i & req_ready_o at edge N -> tx_valid_o=1 after edge N; the granted entry likewise appears one cycle after its grant edge.
REQ-014 SHALL keep a reservation count rsv_cnt (0..4) = buffer entries + uncredited request in output register; +1 on upstream load, -1 on uncredited accept or granted-entry load, net 0 when both occur.
REQ-015 SHALL drive req_ready_o = load-able & no granted entry pending & rsv_cnt < 4, so a retry can never find the buffer full.
REQ-016 SHALL ignore tx_retry_i when tx_credit_o=1 (request held until tx_ready_i) and set err_o.
REQ-017 SHALL process retry capture and grant marking in the same edge; the grant does not match the entry being captured.
REQ-018 SHALL never reorder two granted entries; reissue order = grant order.

Reset
REQ-019 SHALL, on reset, clear the output register (tx_valid_o=0, tx_credit_o=0, tx_id_o=0, tx_payload_o=0), empty the retry buffer, set rsv_cnt=0, and clear err_o; req_ready_o=1 the cycle after reset deasserts.
REQ-020 SHALL, on reset mid-operation, discard all outstanding and retried requests without issuing them.

Configuration
REQ-021 SHALL, with CREDIT_REQ_STATS_EN defined, add output retry_cnt_o [7:0], counting retries, saturating at 255, reset to 0.
REQ-022 SHALL, without CREDIT_REQ_STATS_EN, omit the port and counter entirely; all other behaviour is identical.

Structure
REQ-023 SHALL take ID_W=3, PAYLOAD_W=5, RB_DEPTH=4 and a packed typedef req_t {id, payload} from shared package credit_pkg, also used by the responder.
REQ-024 SHALL implement the retry buffer as sub-module credit_retry_buf, with ports: push, grant id-match, pop-oldest-granted, count, and granted-pending.

Verification
REQ-025 SHALL cover back-to-back accept: ids 1,2,3 with tx_ready_i=1 -> tx ids 1,2,3 on consecutive cycles, tx_credit_o=0, err_o=0.
REQ-026 SHALL cover retry then grant: id 5 payload 0x0A retried, grant id 5 two cycles later -> next cycle tx_id_o=5, payload 0x0A, tx_credit_o=1.
REQ-027 SHALL cover buffer fill: 4 requests all retried -> req_ready_o=0; one grant -> credited reissue, then req_ready_o=1 after its load.
REQ-028 SHALL cover duplicate ids: retry id 2 payloads 0x01 then 0x02, grant id 2 once -> payload 0x01 reissued first, 0x02 still waiting.
REQ-029 SHALL cover errors: grant id 7 with empty buffer -> err_o=1 sticky; tx_retry_i on credited request -> held, err_o=1.
REQ-030 SHALL cover reset with 3 entries buffered -> tx_valid_o=0, rsv_cnt=0, and no reissue after reset.
